// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/capture stage wrapped around a purely combinational n-bit ALU.
// A command (select + operands) is accepted over a valid/ready handshake and
// registered onto the ALU inputs. One cycle later the ALU result and carry are
// captured and offered downstream over a second valid/ready handshake. The
// last result is kept in an accumulator that can replace operand b, so chained
// operations can be issued without the requester tracking the running value.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    stage idle and able to take a command (decoded from state)
//   cmd_sel      ALU operation select
//   cmd_a        operand a
//   cmd_b        operand b (ignored when cmd_use_acc = 1)
//   cmd_use_acc  take operand b from the accumulator
//   acc_clr      synchronous accumulator clear, honoured in every state
//   alu_a        registered operand a to the ALU
//   alu_b        registered operand b to the ALU
//   alu_sel      registered select to the ALU
//   alu_o        ALU result
//   alu_c        ALU carry
//   res_valid    captured result available
//   res_ready    downstream accepts the result
//   res_o        captured result
//   res_c        captured carry
//
// Latency: command accepted at edge k, result valid after edge k+1.
// Throughput: one command per three cycles with res_ready held high.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_sel,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    input  logic         cmd_use_acc,
    input  logic         acc_clr,

    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [2:0]   alu_sel,
    input  logic [n-1:0] alu_o,
    input  logic         alu_c,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [n-1:0] res_o,
    output logic         res_c
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [n-1:0] acc;
    logic         cmd_fire;

    // The only input-to-output-free combinational output: ready is a pure
    // decode of the state register.
    assign cmd_ready = (state == IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            // The ALU settles during this single cycle; no wait states.
            EXEC: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue stage: operands and select onto the ALU inputs
    // ------------------------------------------------------------------
    // alu_b samples acc as it stands before this edge, so a simultaneous
    // acc_clr does not affect the operand of the command being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 3'b000;
        end else if (cmd_fire) begin
            alu_a   <= cmd_a;
            alu_b   <= cmd_use_acc ? acc : cmd_b;
            alu_sel <= cmd_sel;
        end
    end

    // ------------------------------------------------------------------
    // Capture stage: ALU result and carry into the output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_o     <= '0;
            res_c     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (state == EXEC) begin
                res_o     <= alu_o;
                res_c     <= alu_c;
                res_valid <= 1'b1;
            end else if ((state == DONE) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    // Accumulator keeps only the n-bit result; the carry is not folded in.
    // A clear wins over the EXEC capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (state == EXEC) begin
            acc <= alu_o;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_sel;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_acc;
    logic       acc_clr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_o;
    logic       alu_c;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_o;
    logic       res_c;

    int tests  = 0;
    int failed = 0;

    // Reference state: the running accumulator value as defined by the rules
    // (last result, zeroed by clear, carry dropped).
    logic [3:0] model_acc;

    always #5 clk = ~clk;

    // Bench ALU: {c,o} = a + b for every select.
    assign {alu_c, alu_o} = {1'b0, alu_a} + {1'b0, alu_b};

    alu_issue_ctrl #(.n(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sel     (cmd_sel),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .acc_clr     (acc_clr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_o       (alu_o),
        .alu_c       (alu_c),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_o       (res_o),
        .res_c       (res_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full command through the stage starting from IDLE at a negedge.
    // clr_exec raises acc_clr on the EXEC edge; hold keeps res_ready low for
    // that many extra cycles while a competing command is offered.
    task automatic issue(input logic [2:0] sel, input logic [3:0] a, input logic [3:0] b,
                         input logic use_acc, input logic clr_exec, input int hold);
        logic [3:0] eb;
        logic [4:0] sum;
        eb  = use_acc ? model_acc : b;
        sum = {1'b0, a} + {1'b0, eb};

        chk("idle_ready", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_sel     = sel;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        res_ready   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("issue_alu_a",   32'(alu_a),     32'(a));
        chk("issue_alu_b",   32'(alu_b),     32'(eb));
        chk("issue_alu_sel", 32'(alu_sel),   32'(sel));
        chk("exec_ready",    32'(cmd_ready), 32'd0);
        chk("exec_valid",    32'(res_valid), 32'd0);

        acc_clr = clr_exec;
        tick();
        acc_clr   = 1'b0;
        model_acc = clr_exec ? 4'h0 : sum[3:0];
        chk("done_valid", 32'(res_valid), 32'd1);
        chk("done_res_o", 32'(res_o),     32'(sum[3:0]));
        chk("done_res_c", 32'(res_c),     32'(sum[4]));

        for (int i = 0; i < hold; i++) begin
            cmd_valid   = 1'b1;
            cmd_sel     = 3'($urandom);
            cmd_a       = 4'($urandom);
            cmd_b       = 4'($urandom);
            cmd_use_acc = 1'($urandom);
            tick();
            chk("bp_valid",   32'(res_valid), 32'd1);
            chk("bp_res_o",   32'(res_o),     32'(sum[3:0]));
            chk("bp_res_c",   32'(res_c),     32'(sum[4]));
            chk("bp_ready",   32'(cmd_ready), 32'd0);
            chk("bp_alu_a",   32'(alu_a),     32'(a));
            chk("bp_alu_b",   32'(alu_b),     32'(eb));
            chk("bp_alu_sel", 32'(alu_sel),   32'(sel));
        end

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("rel_valid", 32'(res_valid), 32'd0);
        chk("rel_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_sel     = 3'b000;
        cmd_a       = 4'h0;
        cmd_b       = 4'h0;
        cmd_use_acc = 1'b0;
        acc_clr     = 1'b0;
        res_ready   = 1'b0;
        model_acc   = 4'h0;

        // Reset state
        #1;
        chk("rst_ready",   32'(cmd_ready), 32'd1);
        chk("rst_valid",   32'(res_valid), 32'd0);
        chk("rst_res_o",   32'(res_o),     32'd0);
        chk("rst_res_c",   32'(res_c),     32'd0);
        chk("rst_alu_a",   32'(alu_a),     32'd0);
        chk("rst_alu_b",   32'(alu_b),     32'd0);
        chk("rst_alu_sel", 32'(alu_sel),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single op
        issue(3'b101, 4'h2, 4'h3, 1'b0, 1'b0, 0);

        // Reset asserted mid-EXEC discards the in-flight command
        cmd_valid = 1'b1; cmd_sel = 3'b011; cmd_a = 4'h3; cmd_b = 4'h4; cmd_use_acc = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("pre_rst_alu_a", 32'(alu_a), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res_o", 32'(res_o),     32'd0);
        chk("mid_rst_alu_a", 32'(alu_a),     32'd0);
        chk("mid_rst_alu_b", 32'(alu_b),     32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        model_acc = 4'h0;
        tick();
        chk("in_rst_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        issue(3'b000, 4'h6, 4'h1, 1'b0, 1'b0, 0);

        // Backpressure, then the waiting command goes in right after release
        issue(3'b010, 4'h9, 4'h4, 1'b0, 1'b0, 5);
        issue(3'b001, 4'h1, 4'h1, 1'b0, 1'b0, 0);

        // Accumulate chain: 5, 10, 15, then wrap to 4 with carry
        acc_clr = 1'b1;
        tick();
        acc_clr   = 1'b0;
        model_acc = 4'h0;
        for (int i = 0; i < 4; i++) begin
            issue(3'b100, 4'h5, 4'hA, 1'b1, 1'b0, 0);
        end
        chk("chain_last_o", 32'(res_o), 32'h4);
        chk("chain_last_c", 32'(res_c), 32'd1);

        // Clear on the EXEC edge: result still 8, accumulator zeroed
        issue(3'b000, 4'h7, 4'h1, 1'b0, 1'b1, 0);
        chk("clr_col_res_o", 32'(res_o), 32'h8);
        issue(3'b000, 4'h1, 4'hC, 1'b1, 1'b0, 0);
        chk("clr_next_res_o", 32'(res_o), 32'h1);

        // Clear on the accept edge: operand b still takes the old accumulator
        issue(3'b000, 4'h2, 4'h0, 1'b0, 1'b0, 0);
        acc_clr = 1'b1;
        issue(3'b000, 4'h3, 4'h0, 1'b1, 1'b0, 0);
        chk("clr_acc_b_res_o", 32'(res_o), 32'h5);

        // Carry boundaries
        issue(3'b111, 4'hF, 4'h1, 1'b0, 1'b0, 0);
        chk("cb1_res_o", 32'(res_o), 32'h0);
        chk("cb1_res_c", 32'(res_c), 32'd1);
        issue(3'b110, 4'hF, 4'h0, 1'b0, 1'b0, 0);
        chk("cb2_res_o", 32'(res_o), 32'hF);
        chk("cb2_res_c", 32'(res_c), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            issue(3'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/capture stage that sits directly around the combinational n-bit ALU. It accepts operation commands over a valid/ready handshake and registers the operands and select onto the ALU inputs. One cycle later it captures the ALU result and carry, and presents them downstream over a second valid/ready handshake. An internal accumulator holds the last result so that chained operations can use it as operand b.

## Interface
- n, 4, operand/result width; must match the ALU width
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept a command
- cmd_sel  in  3  ALU operation select
- cmd_a  in  n  operand a
- cmd_b  in  n  operand b; ignored when cmd_use_acc=1
- cmd_use_acc  in  1  1 = use accumulator as operand b
- acc_clr  in  1  synchronous accumulator clear
- alu_a  out  n  registered operand a to ALU
- alu_b  out  n  registered operand b to ALU
- alu_sel  out  3  registered select to ALU
- alu_o  in  n  ALU result
- alu_c  in  1  ALU carry
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_o  out  n  captured result
- res_c  out  1  captured carry

## Operation
- FSM has three states: IDLE, EXEC, DONE. Encoding is free.
- cmd_ready = (state == IDLE), decoded combinationally from the state register.
- IDLE:
  - On cmd_valid & cmd_ready, latch alu_a <= cmd_a and alu_sel <= cmd_sel.
  - Latch alu_b <= (cmd_use_acc ? acc : cmd_b). acc is the register value before this edge.
  - Go to EXEC. Without cmd_valid, stay in IDLE and hold all registers.
- EXEC (always exactly one cycle; the ALU settles during it):
  - Capture res_o <= alu_o, res_c <= alu_c, acc <= alu_o.
  - Set res_valid <= 1 and go to DONE.
- DONE:
  - Hold res_o, res_c, res_valid, alu_* and acc stable.
  - On res_ready, clear res_valid and go to IDLE.
  - A command is never accepted in DONE. cmd_ready = 0, so cmd_valid is ignored.
- alu_a, alu_b and alu_sel hold their last values in every state. They change only on command acceptance.
- acc_clr:
  - Sampled in every state; sets acc <= 0.
  - Has priority over the EXEC capture into acc. res_o/res_c are still captured normally.
  - Does not affect alu_b if a command is accepted on the same edge; alu_b takes the pre-clear acc.
- Width rules:
  - The result is exactly n bits plus carry, as produced by the ALU. The stage performs no arithmetic.
  - acc is n bits; the carry is not accumulated.
- Reset (rst_n low, asynchronous, any state, including mid-EXEC or DONE):
  - state = IDLE.
  - alu_a = alu_b = 0, alu_sel = 3'b000.
  - res_o = 0, res_c = 0, res_valid = 0, acc = 0.
  - cmd_ready = 1 while in reset and after release.
  - Any in-flight result is discarded.

## Timing
- Command accepted at rising edge k: alu_a/alu_b/alu_sel are valid after edge k.
- Result is captured at edge k+1; res_valid = 1 after edge k+1 (2-edge latency).
- res_ready high at edge m (m ≥ k+2): res_valid = 0 and cmd_ready = 1 after edge m.
- The next command can be accepted at edge m+1.
- Peak throughput is one command per 3 cycles, with res_ready tied high.
- The ALU combinational path must close within one clk period, from the alu_* registers to the res_* registers.
- No combinational path from any input to any output except state → cmd_ready.

## Test plan
Bench ALU model: {c,o} = a + b for every sel; n = 4.
- Reset: assert rst_n low during EXEC after a=4'h3, b=4'h4 is accepted -> immediately res_valid=0, res_o=0, alu_a=0, cmd_ready=1; after release, a new command completes normally.
- Single op: accept sel=3'b101, a=2, b=3 at edge 1 -> alu_sel=101, alu_a=2, alu_b=3 after edge 1; res_valid=1, res_o=5, res_c=0 after edge 2.
- Backpressure: hold res_ready=0 for 5 cycles while cmd_valid=1 with new operands -> res_o/res_c/res_valid stable, cmd_ready=0, alu_* unchanged; res_ready=1 -> IDLE, the pending command is accepted on the next edge.
- Accumulate chain: pulse acc_clr, then four commands with use_acc=1, a=5 -> res_o = 5, 10, 15, then 4 with res_c=1 (wrap-around).
- Clear collision: acc_clr high on the EXEC edge of a=7, b=1 -> res_o=8, acc=0; the next use_acc command with a=1 -> res_o=1.
- Carry boundary: a=4'hF, b=4'h1 -> res_o=0, res_c=1; a=4'hF, b=4'h0 -> res_o=F, res_c=0.
